// File: rtl/pll_sup_pkg.sv
// PLL lock supervisor shared types and width helpers.
// State encoding plus counter-width derivation used by the top.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam int RST_CYC_DEF    = 16;
  localparam int LOCK_TMO_DEF   = 4096;
  localparam int STABLE_CYC_DEF = 256;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Phase counter width; never below one bit.
  function automatic int cnt_bits(
    input int a,
    input int b,
    input int c
  );
    int w;
    w = $clog2(max3(a, b, c));
    return (w < 1) ? 1 : w;
  endfunction

  localparam int CNT_BITS_DEF =
    cnt_bits(RST_CYC_DEF, LOCK_TMO_DEF, STABLE_CYC_DEF);

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser, cleared to 0 on reset.
// Ports: clk_tb, rst_n (async, active-low), d (async in), q (synced out).
module sync_2ff (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences pll_rst, qualifies lock, releases sys_rst_n.
// Retries timed-out lock attempts, counts lock losses, latches a fault.
// Ports:
//   clk_tb, rst_n (async, active-low), pll_lock (async), fault_clr (pulse)
//   pll_rst, sys_rst_n, locked_ok, fault, retry_cnt[1:0],
//   loss_cnt[CNT_W-1:0], state[2:0]
// Optional: define PLL_FREQ_CHK_EN to add clk_mon input, freq_err output
// and a windowed clk_mon edge-count check that acts as a lock loss in RUN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYC    = 16,
  parameter int LOCK_TMO   = 4096,
  parameter int STABLE_CYC = 256,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_W      = 8
`ifdef PLL_FREQ_CHK_EN
  ,
  parameter int WIN_CYC    = 1024,
  parameter int EXP_EDGES  = 41,
  parameter int TOL        = 2
`endif
) (
  input  logic             clk_tb,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             fault_clr,
`ifdef PLL_FREQ_CHK_EN
  input  logic             clk_mon,
  output logic             freq_err,
`endif
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             locked_ok,
  output logic             fault,
  output logic [1:0]       retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [2:0]       state
);

  localparam int CW =
    cnt_bits(RST_CYC, LOCK_TMO, STABLE_CYC);

  localparam logic [CW-1:0] RST_LAST =
    CW'(RST_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(LOCK_TMO - 1);
  localparam logic [CW-1:0] STB_LAST =
    CW'(STABLE_CYC - 1);
  // The lk=1 cycle that enters STABLE is the first counted one.
  localparam logic [CW-1:0] STB_INIT =
    (STABLE_CYC > 1) ? CW'(1) : CW'(0);
  localparam logic [1:0] RETRY_MAX =
    2'(MAX_RETRY);

  state_e      st;
  logic [CW-1:0] cnt;
  logic        lk;
  logic        lost;
  logic [1:0]  retry_nx;

  sync_2ff u_lk_sync (
    .clk_tb (clk_tb),
    .rst_n  (rst_n),
    .d      (pll_lock),
    .q      (lk)
  );

  assign retry_nx = retry_cnt + 2'd1;
  assign state    = st;

`ifdef PLL_FREQ_CHK_EN
  localparam int WW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam int EW = $clog2(WIN_CYC + 1);
  localparam logic [WW-1:0] WIN_LAST =
    WW'(WIN_CYC - 1);

  logic          mon_s;
  logic          mon_q;
  logic          mon_rise;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] edg_cnt;
  logic [EW-1:0] edg_tot;
  logic          freq_bad;

  sync_2ff u_mon_sync (
    .clk_tb (clk_tb),
    .rst_n  (rst_n),
    .d      (clk_mon),
    .q      (mon_s)
  );

  assign mon_rise = mon_s & ~mon_q;
  assign edg_tot  = edg_cnt + EW'(mon_rise);

  // Evaluated on the last cycle of a window, edge of that cycle included.
  assign freq_bad = (st == RUN) &&
                    (win_cnt == WIN_LAST) &&
                    ((int'(edg_tot) < EXP_EDGES - TOL) ||
                     (int'(edg_tot) > EXP_EDGES + TOL));

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      mon_q    <= 1'b0;
      win_cnt  <= '0;
      edg_cnt  <= '0;
      freq_err <= 1'b0;
    end else begin
      mon_q <= mon_s;
      if (st != RUN || win_cnt == WIN_LAST) begin
        win_cnt <= '0;
        edg_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        edg_cnt <= edg_tot;
      end
      if (freq_bad)
        freq_err <= 1'b1;
    end
  end

  assign lost = ~lk | freq_bad;
`else
  assign lost = ~lk;
`endif

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RST_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      locked_ok <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 2'd0;
      loss_cnt  <= '0;
    end else begin
      case (st)
        RST_PLL: begin
          if (cnt == RST_LAST) begin
            st      <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock has priority over a coincident timeout.
          if (lk) begin
            st  <= STABLE;
            cnt <= STB_INIT;
          end else if (cnt == TMO_LAST) begin
            cnt       <= '0;
            pll_rst   <= 1'b1;
            retry_cnt <= retry_nx;
            if (retry_nx == RETRY_MAX) begin
              st    <= FAULT;
              fault <= 1'b1;
            end else begin
              st <= RST_PLL;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABLE: begin
          if (!lk) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STB_LAST) begin
            st        <= RUN;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
            locked_ok <= 1'b1;
            retry_cnt <= 2'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (lost) begin
            st        <= RST_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            locked_ok <= 1'b0;
            if (loss_cnt != {CNT_W{1'b1}})
              loss_cnt <= loss_cnt + CNT_W'(1);
          end
        end
        FAULT: begin
          if (fault_clr) begin
            st        <= RST_PLL;
            cnt       <= '0;
            fault     <= 1'b0;
            retry_cnt <= 2'd0;
          end
        end
        default: begin
          st        <= RST_PLL;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          locked_ok <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor.
// Expected values are queued at stimulus time and popped on DUT response.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic       rst_n;
  logic       pll_lock;
  logic       fault_clr;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked_ok;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  logic       s_rst_n;
  logic       s_lock;
  logic       s_clr;
  logic       s_pll_rst;
  logic       s_sys_rst_n;
  logic       s_locked_ok;
  logic       s_fault;
  logic [1:0] s_retry_cnt;
  logic [7:0] s_loss_cnt;
  logic [2:0] s_state;

`ifdef PLL_FREQ_CHK_EN
  logic clk_mon = 1'b0;
  logic freq_err;
  logic s_freq_err;
  always #125 clk_mon = ~clk_mon;
`endif

  pll_lock_supervisor dut (
    .clk_tb    (clk_tb),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .fault_clr (fault_clr),
`ifdef PLL_FREQ_CHK_EN
    .clk_mon   (clk_mon),
    .freq_err  (freq_err),
`endif
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .locked_ok (locked_ok),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  pll_lock_supervisor #(
    .RST_CYC    (2),
    .LOCK_TMO   (64),
    .STABLE_CYC (4),
    .MAX_RETRY  (3),
    .CNT_W      (8)
  ) dut_s (
    .clk_tb    (clk_tb),
    .rst_n     (s_rst_n),
    .pll_lock  (s_lock),
    .fault_clr (s_clr),
`ifdef PLL_FREQ_CHK_EN
    .clk_mon   (clk_mon),
    .freq_err  (s_freq_err),
`endif
    .pll_rst   (s_pll_rst),
    .sys_rst_n (s_sys_rst_n),
    .locked_ok (s_locked_ok),
    .fault     (s_fault),
    .retry_cnt (s_retry_cnt),
    .loss_cnt  (s_loss_cnt),
    .state     (s_state)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      0:       return 32'(pll_rst);
      1:       return 32'(sys_rst_n);
      2:       return 32'(fault);
      3:       return 32'(state);
      4:       return 32'(s_locked_ok);
      5:       return 32'(s_state);
      default: return 32'd0;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_tb);
  endtask

  // Counts negedges until the selected output reaches v (bounded).
  task automatic wait_eq(
    input  int          sel,
    input  logic [31:0] v,
    input  int          max,
    output int          n
  );
    n = 0;
    while (sig(sel) !== v && n <= max) begin
      @(negedge clk_tb);
      n++;
    end
    if (sig(sel) !== v)
      chk("wait_tmo", sig(sel), v);
  endtask

  task automatic chk_rst(input string t);
    push({t, "_pll_rst"}, 1);
    push({t, "_sys_rst_n"}, 0);
    push({t, "_locked_ok"}, 0);
    push({t, "_fault"}, 0);
    push({t, "_retry"}, 0);
    push({t, "_loss"}, 0);
    push({t, "_state"}, 0);
    pop(32'(pll_rst));
    pop(32'(sys_rst_n));
    pop(32'(locked_ok));
    pop(32'(fault));
    pop(32'(retry_cnt));
    pop(32'(loss_cnt));
    pop(32'(state));
  endtask

  task automatic do_reset(input string t);
    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    fault_clr = 1'b0;
    cyc(3);
    chk_rst(t);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    fault_clr = 1'b0;
    s_rst_n   = 1'b0;
    s_lock    = 1'b0;
    s_clr     = 1'b0;
    @(negedge clk_tb);

    // Nominal lock and release
    do_reset("t1_rst");
    push("t1_prst_w", 16);
    wait_eq(0, 0, 40, n);
    pop(32'(n));
    cyc(34);
    pll_lock = 1'b1;
    push("t1_release_lat", 2 + 256);
    wait_eq(1, 1, 400, n);
    pop(32'(n));
    push("t1_locked_ok", 1);
    push("t1_retry", 0);
    push("t1_state", 3);
    push("t1_pll_rst", 0);
    pop(32'(locked_ok));
    pop(32'(retry_cnt));
    pop(32'(state));
    pop(32'(pll_rst));
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    cyc(2);
    push("t1_clr_ignored", 3);
    pop(32'(state));

    // Lock never arrives: three attempts then FAULT
    do_reset("t2_rst");
    for (int k = 0; k < 3; k++) begin
      push("t2_prst_w", 16);
      wait_eq(0, 0, 40, n);
      pop(32'(n));
      push("t2_tmo", 4096);
      wait_eq((k == 2) ? 2 : 0, 1, 4200, n);
      pop(32'(n));
      if (k < 2) begin
        push("t2_retry", 32'(k + 1));
        pop(32'(retry_cnt));
      end
    end
    push("t2_fault", 1);
    push("t2_state", 4);
    push("t2_retry", 3);
    push("t2_sys_rst_n", 0);
    push("t2_pll_rst", 1);
    pop(32'(fault));
    pop(32'(state));
    pop(32'(retry_cnt));
    pop(32'(sys_rst_n));
    pop(32'(pll_rst));
    cyc(10);
    push("t2_fault_hold", 4);
    pop(32'(state));
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    push("t2_clr_state", 0);
    push("t2_clr_retry", 0);
    push("t2_clr_fault", 0);
    push("t2_clr_pll_rst", 1);
    pop(32'(state));
    pop(32'(retry_cnt));
    pop(32'(fault));
    pop(32'(pll_rst));

    // Lock glitch while qualifying
    do_reset("t3_rst");
    wait_eq(0, 0, 40, n);
    pll_lock = 1'b1;
    wait_eq(3, 2, 10, n);
    cyc(99);
    pll_lock = 1'b0;
    cyc(5);
    pll_lock = 1'b1;
    push("t3_back_wait", 1);
    push("t3_no_retry", 0);
    pop(32'(state));
    pop(32'(retry_cnt));
    push("t3_release_lat", 2 + 256);
    wait_eq(1, 1, 400, n);
    pop(32'(n));

    // Lock loss in RUN
    pll_lock = 1'b0;
    push("t4_sys_fall", 3);
    wait_eq(1, 0, 10, n);
    pop(32'(n));
    push("t4_loss", 1);
    push("t4_state", 0);
    push("t4_pll_rst", 1);
    push("t4_locked_ok", 0);
    pop(32'(loss_cnt));
    pop(32'(state));
    pop(32'(pll_rst));
    pop(32'(locked_ok));
    pll_lock = 1'b1;
    push("t4_prst_w", 16);
    wait_eq(0, 0, 40, n);
    pop(32'(n));

    // Async reset in STABLE clears everything incl. loss_cnt
    wait_eq(3, 2, 10, n);
    cyc(20);
    #1 rst_n = 1'b0;
    #1 chk_rst("t5_async");
    cyc(3);
    rst_n = 1'b1;
    push("t5_prst_w", 16);
    wait_eq(0, 0, 40, n);
    pop(32'(n));

    // loss_cnt saturation on the short-timing instance
    s_rst_n = 1'b1;
    s_lock  = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      wait_eq(4, 1, 60, n);
      s_lock = 1'b0;
      wait_eq(5, 0, 10, n);
      s_lock = 1'b1;
      if (i == 1 || i == 10 || i == 254 || i == 255 || i == 300) begin
        push("t6_loss", 32'((i > 255) ? 255 : i));
        pop(32'(s_loss_cnt));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
